bcd_conversion_scheduler: RTL and testbench
===========================================

Name: bcd_conversion_scheduler

Overview:
Shares one iterative (shift-add-3) binary-to-BCD engine between NUM_REQ requesters, such as the up-counter and the display-driver setpoint, using round-robin arbitration.
- Converts one bit per clock, replacing a fully unrolled combinational converter with a small, multi-cycle datapath.
- Returns the packed BCD result and the winning requester's tag to the display driver.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BIN_W, 12, binary operand width
DIGITS, 4, BCD digits produced; elaboration error if 10^DIGITS <= 2^BIN_W-1
TAG_W, 1, width of requester index = max(1, clog2(NUM_REQ))

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester conversion request, level, held until grant seen
bin_in  in  NUM_REQ*BIN_W  packed operands, requester k at [k*BIN_W +: BIN_W]
grant  out  NUM_REQ  one-hot, registered, high exactly one cycle when operand captured
busy  out  1  high while a conversion is in flight (state != IDLE)
bcd_out  out  4*DIGITS  packed BCD result, digit 0 (ones) in [3:0]; holds last result
bcd_valid  out  1  one-cycle pulse, bcd_out/bcd_tag valid
bcd_tag  out  TAG_W  index of requester whose result is on bcd_out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, busy=0, bcd_out=0, bcd_valid=0, bcd_tag=0, shift count=0, rr pointer=NUM_REQ-1 so requester 0 wins first.
- Reset mid-conversion: the in-flight result is discarded and no bcd_valid is produced.
- FSM states:
  - IDLE: at edge E0 with any req high:
    - select the winner by round-robin starting at pointer+1 modulo NUM_REQ;
    - load the working register: BCD field=0, binary field=bin_in[winner];
    - latch the tag and update the pointer to the winner;
    - grant[winner]=1 for cycle E0..E1; go to SHIFT with count=0.
    - No req: stay in IDLE with all pulses 0.
  - SHIFT: each edge applies one step, then count increments:
    - every BCD digit >= 5 gets +3 (4-bit wrap not possible after the correction rule);
    - then the whole {bcd, bin} register shifts left by 1.
    - At the edge where count==BIN_W-1, the final step result goes to bcd_out, bcd_valid=1, bcd_tag=latched tag, and the state returns to IDLE.
- Latency: grant high in cycle E0..E1; bcd_valid high in cycle E_BIN_W..E_BIN_W+1 (12 cycles after the grant cycle for the default BIN_W=12).
- Throughput: a new request can be sampled on the same edge that ends the bcd_valid cycle. Minimum spacing is BIN_W+1 cycles per conversion.
- req is ignored outside IDLE; there is no queuing. A requester must deassert req in the cycle it sees grant, or it re-enters arbitration.
- Simultaneous requests: exactly one grant. With all requesters continuously requesting, service strictly rotates 0,1,..,NUM_REQ-1,0.
- bin_in is sampled only at the capture edge; later changes do not affect the result.
- grant and bcd_valid are never high in the same cycle. busy=1 from the cycle after capture through the last SHIFT cycle, and 0 in the bcd_valid cycle.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, SHIFT);
  - the clog2 function used for TAG_W and the counter width;
  - the BCD digit width localparam (4).
- Sub-module bcd_dabble_step (combinational, parameter DIGITS, BIN_W):
  - input {bcd, bin}; output the corrected-and-shifted {bcd, bin};
  - instantiated once in the SHIFT datapath.

Test Plan:
- Single request: req[0]=1, bin_in[0]=12'd255 → grant=2'b01 for one cycle; 12 cycles later, bcd_valid=1 with bcd_out=16'h0255 and bcd_tag=0.
- Extremes:
  - bin 12'd0 → 16'h0000;
  - bin 12'd4095 → 16'h4095;
  - bin 12'd999 → 16'h0999;
  - bin 12'd1000 → 16'h1000.
  - Also check exhaustively against a reference model for all 4096 values.
- Contention: req=2'b11 held continuously, bin0=12'd42, bin1=12'd3071 → grants alternate 01,10,01,...; results 16'h0042 tag 0 and 16'h3071 tag 1 alternate; consecutive bcd_valid pulses exactly 13 cycles apart.
- Operand change after grant: change bin_in[0] from 12'd100 to 12'd7 one cycle after grant → bcd_out=16'h0100.
- Reset mid-operation: drop rst_n 5 cycles into SHIFT → all outputs 0 immediately. After release, no bcd_valid occurs, bcd_out stays 0, and the next request goes to requester 0.
- Late request: req[1] rises while busy → no grant until the bcd_valid cycle's ending edge. bcd_out holds its previous value unchanged until the new bcd_valid.

Source files
------------

// File: rtl/bcd_conversion_scheduler_pkg.sv
// Shared definitions for the round-robin shared binary-to-BCD converter.
// FSM encodings, BCD digit width and the constant clog2 used for sizing.
package bcd_conversion_scheduler_pkg;

   localparam int DIG_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_conversion_scheduler_if.sv
// Request/result bundle between the requesters, the converter and the display driver.
// req is a level held until grant; results are single-cycle pulses with no backpressure.
interface bcd_conversion_scheduler_if
   import bcd_conversion_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int BIN_W   = 12,
   parameter int DIGITS  = 4,
   parameter int TAG_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*BIN_W-1:0] bin_in;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;
   logic [DIG_W*DIGITS-1:0]  bcd_out;
   logic                     bcd_valid;
   logic [TAG_W-1:0]         bcd_tag;

   modport master (
      output req, bin_in,
      input  grant, busy, bcd_out, bcd_valid, bcd_tag
   );

   modport slave (
      input  req, bin_in,
      output grant, busy, bcd_out, bcd_valid, bcd_tag
   );
endinterface

// File: rtl/bcd_dabble_step.sv
// One shift-add-3 step: add 3 to every BCD digit >= 5, then shift {bcd, bin} left by one.
// Purely combinational, zero latency, no handshake.
module bcd_dabble_step
   import bcd_conversion_scheduler_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 12
) (
   input  logic [DIG_W*DIGITS+BIN_W-1:0] din,
   output logic [DIG_W*DIGITS+BIN_W-1:0] dout
);
   logic [DIG_W*DIGITS+BIN_W-1:0] adj;

   always_comb begin
      adj = din;
      for (int d = 0; d < DIGITS; d++) begin
         if (din[BIN_W+DIG_W*d +: DIG_W] >= 4'd5) begin
            adj[BIN_W+DIG_W*d +: DIG_W] = din[BIN_W+DIG_W*d +: DIG_W] + 4'd3;
         end
      end
   end

   assign dout = adj << 1;
endmodule

// File: rtl/bcd_conversion_scheduler.sv
// Round-robin shares one bit-serial binary-to-BCD engine among NUM_REQ requesters.
// Result BIN_W cycles after the grant cycle; requests are not sampled while busy (no queuing).
module bcd_conversion_scheduler
   import bcd_conversion_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int BIN_W   = 12,
   parameter int DIGITS  = 4,
   parameter int TAG_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
   input logic clk,
   input logic rst_n,
   bcd_conversion_scheduler_if.slave bus
);
   localparam int W     = DIG_W*DIGITS + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? clog2(BIN_W) : 1;

   if (10**DIGITS <= 2**BIN_W - 1) begin : g_digits_chk
      $error("DIGITS too small to hold the largest BIN_W operand");
   end

   state_t                  state, state_nxt;
   logic [W-1:0]            work, step_out;
   logic [CNT_W-1:0]        cnt;
   logic [TAG_W-1:0]        rr_ptr, winner, tag_q, bcd_tag_q;
   logic [NUM_REQ-1:0]      grant_q;
   logic [DIG_W*DIGITS-1:0] bcd_q;
   logic                    bcd_valid_q;
   logic                    start, done;
   logic [TAG_W-1:0]        idx_t;

   bcd_dabble_step #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_step (
      .din  (work),
      .dout (step_out)
   );

   // Scan downward so the candidate nearest pointer+1 is written last and wins.
   always_comb begin
      winner = rr_ptr;
      idx_t  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx_t = TAG_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (bus.req[idx_t]) begin
            winner = idx_t;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req) begin
               start     = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CNT_W'(BIN_W-1)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work        <= '0;
         cnt         <= '0;
         rr_ptr      <= TAG_W'(NUM_REQ-1);
         tag_q       <= '0;
         grant_q     <= '0;
         bcd_q       <= '0;
         bcd_valid_q <= 1'b0;
         bcd_tag_q   <= '0;
      end else begin
         grant_q     <= '0;
         bcd_valid_q <= 1'b0;
         if (start) begin
            work    <= {{(DIG_W*DIGITS){1'b0}}, bus.bin_in[winner*BIN_W +: BIN_W]};
            tag_q   <= winner;
            rr_ptr  <= winner;
            cnt     <= '0;
            grant_q <= NUM_REQ'(1) << winner;
         end
         if (state == SHIFT) begin
            work <= step_out;
            cnt  <= cnt + 1'b1;
         end
         if (done) begin
            bcd_q       <= step_out[W-1 -: DIG_W*DIGITS];
            bcd_valid_q <= 1'b1;
            bcd_tag_q   <= tag_q;
         end
      end
   end

   assign bus.grant     = grant_q;
   assign bus.busy      = (state != IDLE);
   assign bus.bcd_out   = bcd_q;
   assign bus.bcd_valid = bcd_valid_q;
   assign bus.bcd_tag   = bcd_tag_q;
endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// Directed bench for the shared BCD converter: latency, extremes, contention, reset, sweep.
module tb_bcd_conversion_scheduler;
   localparam int NR = 2;
   localparam int BW = 12;
   localparam int DG = 4;
   localparam int TW = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   bcd_conversion_scheduler_if #(.NUM_REQ(NR), .BIN_W(BW), .DIGITS(DG), .TAG_W(TW)) bus ();

   bcd_conversion_scheduler #(.NUM_REQ(NR), .BIN_W(BW), .DIGITS(DG), .TAG_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ref_bcd(input int v);
      return 16'(((v/1000)%10) << 12 | ((v/100)%10) << 8 | ((v/10)%10) << 4 | (v%10));
   endfunction

   task automatic set_bin(input int k, input logic [11:0] val);
      if (k == 0) bus.bin_in[11:0] = val;
      else        bus.bin_in[23:12] = val;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (bus.grant == '0 && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.bcd_valid && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic conv(input int k, input logic [11:0] val, input logic [15:0] exp_bcd, input string tag);
      int n;
      set_bin(k, val);
      bus.req = (k == 0) ? 2'b01 : 2'b10;
      wait_grant(n);
      bus.req = '0;
      check({tag, "_gnt"}, 32'(bus.grant), (k == 0) ? 32'h1 : 32'h2);
      check({tag, "_busy"}, 32'(bus.busy), 32'h1);
      wait_valid(n);
      check({tag, "_lat"}, n, 12);
      check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp_bcd));
      check({tag, "_tag"}, 32'(bus.bcd_tag), 32'(k));
      check({tag, "_vbusy"}, 32'(bus.busy), 32'h0);
   endtask

   initial begin
      int n, g1, v0, v1, c;
      logic [1:0]  gv;
      logic [15:0] b0, b1;
      logic        t1, hold_ok, ovl, novalid, zero_ok;
      int gc[$], gval[$], vc[$], vb[$], vt[$];

      bus.req    = '0;
      bus.bin_in = '0;
      #12;
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_bcd", 32'(bus.bcd_out), 0);
      check("rst_valid", 32'(bus.bcd_valid), 0);
      check("rst_tag", 32'(bus.bcd_tag), 0);
      tick();
      rst_n = 1'b1;
      tick();

      conv(0, 12'd255, 16'h0255, "single");
      conv(1, 12'd0, 16'h0000, "zero");
      conv(0, 12'd4095, 16'h4095, "max");
      conv(1, 12'd999, 16'h0999, "n999");
      conv(0, 12'd1000, 16'h1000, "n1000");

      // operand changes one cycle after grant must not disturb the result
      set_bin(0, 12'd100);
      bus.req = 2'b01;
      wait_grant(n);
      bus.req = '0;
      check("opchg_gnt", 32'(bus.grant), 1);
      tick();
      set_bin(0, 12'd7);
      wait_valid(n);
      check("opchg_lat", n, 11);
      check("opchg_bcd", 32'(bus.bcd_out), 32'h0100);

      // late request from requester 1 while requester 0 is converting
      set_bin(0, 12'd500);
      bus.req = 2'b01;
      wait_grant(n);
      bus.req = '0;
      g1 = -1; v0 = -1; v1 = -1; gv = '0; b0 = '0; b1 = '0; t1 = 1'b0; hold_ok = 1'b1;
      for (c = 1; c <= 40; c++) begin
         tick();
         if (c == 3) begin
            set_bin(1, 12'd77);
            bus.req = 2'b10;
         end
         if (bus.grant != '0 && g1 < 0) begin
            g1 = c;
            gv = bus.grant;
            bus.req = '0;
         end
         if (bus.bcd_valid) begin
            if (v0 < 0) begin
               v0 = c; b0 = bus.bcd_out;
            end else if (v1 < 0) begin
               v1 = c; b1 = bus.bcd_out; t1 = bus.bcd_tag;
            end
         end else if (v0 < 0 && bus.bcd_out !== 16'h0100) begin
            hold_ok = 1'b0;
         end else if (v0 >= 0 && v1 < 0 && bus.bcd_out !== 16'h0500) begin
            hold_ok = 1'b0;
         end
      end
      check("late_v0", v0, 12);
      check("late_b0", 32'(b0), 32'h0500);
      check("late_g1", g1, 13);
      check("late_gv", 32'(gv), 2);
      check("late_v1", v1, 25);
      check("late_b1", 32'(b1), 32'h0077);
      check("late_t1", 32'(t1), 1);
      check("late_hold", 32'(hold_ok), 1);

      // both requesters held continuously: strict alternation, 13-cycle spacing
      set_bin(0, 12'd42);
      set_bin(1, 12'd3071);
      bus.req = 2'b11;
      ovl = 1'b0;
      for (c = 1; c <= 60; c++) begin
         tick();
         if (bus.grant != '0) begin
            gc.push_back(c);
            gval.push_back(int'(bus.grant));
         end
         if (bus.bcd_valid) begin
            vc.push_back(c);
            vb.push_back(int'(bus.bcd_out));
            vt.push_back(int'(bus.bcd_tag));
         end
         if (bus.bcd_valid && bus.grant != '0) ovl = 1'b1;
      end
      bus.req = '0;
      check("ctn_ngnt", gc.size(), 5);
      check("ctn_nval", vc.size(), 4);
      check("ctn_ovl", 32'(ovl), 0);
      if (gc.size() > 0) check("ctn_g0c", gc[0], 1);
      for (int i = 0; i < 4; i++) begin
         if (i < gval.size()) check("ctn_gnt", gval[i], (i % 2 == 0) ? 1 : 2);
         if (i < vb.size()) begin
            check("ctn_bcd", vb[i], (i % 2 == 0) ? 32'h0042 : 32'h3071);
            check("ctn_tag", vt[i], i % 2);
         end
         if (i > 0 && i < vc.size()) check("ctn_gap", vc[i] - vc[i-1], 13);
      end
      if (vc.size() > 0) check("ctn_v0c", vc[0], 13);
      n = 0;
      while (bus.busy && n < 30) begin
         tick();
         n++;
      end
      check("ctn_drain", 32'(bus.busy), 0);
      tick();

      // asynchronous reset five cycles into SHIFT discards the conversion
      set_bin(0, 12'd300);
      bus.req = 2'b01;
      wait_grant(n);
      bus.req = '0;
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_grant", 32'(bus.grant), 0);
      check("mrst_busy", 32'(bus.busy), 0);
      check("mrst_bcd", 32'(bus.bcd_out), 0);
      check("mrst_valid", 32'(bus.bcd_valid), 0);
      check("mrst_tag", 32'(bus.bcd_tag), 0);
      tick();
      rst_n = 1'b1;
      novalid = 1'b1;
      zero_ok = 1'b1;
      repeat (20) begin
         tick();
         if (bus.bcd_valid) novalid = 1'b0;
         if (bus.bcd_out !== 16'h0000) zero_ok = 1'b0;
      end
      check("mrst_novalid", 32'(novalid), 1);
      check("mrst_zero", 32'(zero_ok), 1);
      set_bin(0, 12'd5);
      set_bin(1, 12'd6);
      bus.req = 2'b11;
      wait_grant(n);
      bus.req = '0;
      check("mrst_ptr", 32'(bus.grant), 1);
      wait_valid(n);
      check("mrst_bcd2", 32'(bus.bcd_out), 32'h0005);
      check("mrst_tag2", 32'(bus.bcd_tag), 0);

      for (int v = 0; v < 4096; v++) begin
         conv(v % 2, 12'(v), ref_bcd(v), "sweep");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
